// File: rtl/digitalclock_pkg.sv
// digitalclock_pkg: mode encoding shared with the mode FSM, plus time field limits.
package digitalclock_pkg;
   typedef enum logic [1:0] {
      MODE_RUN       = 2'b00,
      MODE_SET_HOURS = 2'b01,
      MODE_SET_MIN   = 2'b10
   } clk_mode_t;
   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
endpackage

// File: rtl/digitalclock_timekeeper_if.sv
// digitalclock_timekeeper_if: mode/button inputs and BCD display outputs of the timekeeper.
interface digitalclock_timekeeper_if;
   logic [1:0] state_enum;
   logic       inc;
   logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
   logic       sec_tick;
   modport master (
      output state_enum, inc,
      input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, sec_tick
   );
   modport slave (
      input  state_enum, inc,
      output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, sec_tick
   );
endinterface

// File: rtl/digitalclock_bcd_counter.sv
// digitalclock_bcd_counter: two-digit BCD counter 0..MAX; wrap flags the enabled MAX->0 step.
module digitalclock_bcd_counter #(
   parameter int MAX = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       wrap
);
   assign wrap = en && tens == 4'(MAX / 10) && ones == 4'(MAX % 10);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         tens <= '0;
         ones <= '0;
      end else if (clr || wrap) begin
         tens <= '0;
         ones <= '0;
      end else if (en) begin
         ones <= ones == 4'd9 ? 4'd0 : ones + 4'd1;
         tens <= ones == 4'd9 ? tens + 4'd1 : tens;
      end
endmodule

// File: rtl/digitalclock_timekeeper.sv
// digitalclock_timekeeper: HH:MM:SS BCD timekeeping with 1 Hz prescaler and per-press field setting.
module digitalclock_timekeeper
   import digitalclock_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int HOUR_MAX = 23
) (
   input logic                     clk,
   input logic                     rst,
   digitalclock_timekeeper_if.slave bus
);
   localparam int PW = $clog2(CLK_HZ);
   clk_mode_t     mode;
   logic          run, set_h, set_m, inc_q, inc_rise, pre_wrap;
   logic          sec_wrap, min_wrap, min_en, hr_en, unused_hr_wrap;
   logic [PW-1:0] pre;
   always_comb begin
      mode     = clk_mode_t'(bus.state_enum);
      set_h    = mode == MODE_SET_HOURS;
      set_m    = mode == MODE_SET_MIN;
      run      = !set_h && !set_m;
      inc_rise = bus.inc && !inc_q;
      pre_wrap = run && pre == PW'(CLK_HZ - 1);
      min_en   = run ? sec_wrap : set_m && inc_rise;
      hr_en    = run ? min_wrap : set_h && inc_rise;
   end
   // Set modes pin the prescaler at 0 so RUN always restarts a full second.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pre          <= '0;
         inc_q        <= 1'b0;
         bus.sec_tick <= 1'b0;
      end else begin
         pre          <= (pre_wrap || !run) ? '0 : pre + 1'b1;
         inc_q        <= bus.inc;
         bus.sec_tick <= pre_wrap;
      end
   digitalclock_bcd_counter #(.MAX(SEC_MAX)) u_sec (
      .clk(clk), .rst(rst), .clr(!run), .en(pre_wrap),
      .tens(bus.sec_tens), .ones(bus.sec_ones), .wrap(sec_wrap)
   );
   digitalclock_bcd_counter #(.MAX(MIN_MAX)) u_min (
      .clk(clk), .rst(rst), .clr(1'b0), .en(min_en),
      .tens(bus.min_tens), .ones(bus.min_ones), .wrap(min_wrap)
   );
   digitalclock_bcd_counter #(.MAX(HOUR_MAX)) u_hr (
      .clk(clk), .rst(rst), .clr(1'b0), .en(hr_en),
      .tens(bus.hr_tens), .ones(bus.hr_ones), .wrap(unused_hr_wrap)
   );
endmodule

// File: tb/tb_digitalclock_timekeeper.sv
// tb_digitalclock_timekeeper: random and directed stimulus scored against a seconds-of-day model.
module tb_digitalclock_timekeeper;
   localparam int CLK_HZ = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0, bad = 0, ticks = 0;
   int   t_sec = 0, pre = 0;
   bit   inc_q = 1'b0;
   logic [24:0] exp_q[$];
   digitalclock_timekeeper_if bus();
   digitalclock_timekeeper #(.CLK_HZ(CLK_HZ), .HOUR_MAX(23)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [23:0] to_bcd(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction
   function automatic logic [23:0] dut_time();
      return {bus.hr_tens, bus.hr_ones, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   endfunction
   task automatic check(input string name, input logic [24:0] got, input logic [24:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask
   // Drive one cycle of inputs and predict the state visible after the next rising edge.
   task automatic step(input logic [1:0] m, input logic i);
      bit run, rise, tick;
      int h, mn;
      bus.state_enum = m;
      bus.inc = i;
      run  = (m != 2'd1) && (m != 2'd2);
      rise = i && !inc_q;
      tick = 1'b0;
      if (run) begin
         if (pre == CLK_HZ - 1) begin
            pre = 0;
            t_sec = (t_sec + 1) % 86400;
            tick = 1'b1;
         end else pre++;
      end else begin
         pre = 0;
         h = t_sec / 3600;
         mn = (t_sec / 60) % 60;
         if (rise && m == 2'd1) h = (h + 1) % 24;
         if (rise && m == 2'd2) mn = (mn + 1) % 60;
         t_sec = h * 3600 + mn * 60;
      end
      inc_q = i;
      exp_q.push_back({tick, to_bcd(t_sec)});
      @(negedge clk);
   endtask
   task automatic press(input logic [1:0] m, input int n);
      for (int k = 0; k < n; k++) begin
         step(m, 1'b1);
         step(m, 1'b0);
      end
   endtask
   task automatic run_cycles(input logic [1:0] m, input int n);
      for (int k = 0; k < n; k++) step(m, 1'b0);
   endtask
   task automatic async_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check("async_reset", {bus.sec_tick, dut_time()}, 25'd0);
      t_sec = 0;
      pre = 0;
      inc_q = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask
   initial begin
      logic [24:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cycle", {bus.sec_tick, dut_time()}, e);
            if (bus.sec_tick) ticks++;
         end
      end
   end
   initial begin
      bus.state_enum = 2'd0;
      bus.inc = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", {bus.sec_tick, dut_time()}, 25'd0);
      rst = 1'b1;
      ticks = 0;
      run_cycles(2'd0, 16);
      check("run16_time", {1'b0, dut_time()}, {1'b0, 24'h000004});
      check("run16_ticks", 25'(ticks), 25'd4);
      press(2'd1, 23);
      press(2'd2, 59);
      run_cycles(2'd0, 59 * CLK_HZ);
      check("pre_rollover", {1'b0, dut_time()}, {1'b0, 24'h235959});
      ticks = 0;
      run_cycles(2'd0, CLK_HZ);
      check("rollover", {1'b0, dut_time()}, 25'd0);
      check("rollover_ticks", 25'(ticks), 25'd1);
      press(2'd1, 25);
      check("set_hours", {1'b0, dut_time()}, {1'b0, 24'h010000});
      press(2'd2, 61);
      check("set_minutes", {1'b0, dut_time()}, {1'b0, 24'h010100});
      for (int k = 0; k < 20; k++) step(2'd1, 1'b1);
      step(2'd1, 1'b0);
      check("held_button", {1'b0, dut_time()}, {1'b0, 24'h020100});
      run_cycles(2'd3, 2 * CLK_HZ);
      check("mode3_run", {1'b0, dut_time()}, {1'b0, 24'h020102});
      press(2'd1, 10);
      press(2'd2, 33);
      run_cycles(2'd0, 56 * CLK_HZ);
      check("at_123456", {1'b0, dut_time()}, {1'b0, 24'h123456});
      async_reset();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 299) == 0) async_reset();
         else step($urandom_range(0, 7) < 5 ? 2'($urandom_range(0, 3)) & 2'b11 : 2'd0,
                   1'($urandom_range(0, 1)));
      end
      repeat (2) @(negedge clk);
      check("queue_drained", 25'(exp_q.size()), 25'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
